mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory access sequencer for the CPU datapath's MAR/MDR path. It accepts single-word read or write requests from the control unit. It then drives the MAR load, the MDR input-select (`Read`), the MDR load and the memory strobes in a fixed order, and waits on the memory ready handshake with a bounded timeout. It sits between the control unit and the MAR/MDR/memory cluster, so the control unit issues one request and waits for `done` or `timeout_err` instead of hand-sequencing each step.

## Interface

Parameters:
- `TIMEOUT`, default 15: maximum number of wait cycles allowed for `mem_ready` per access. Legal range is ≥ 1.
- `CNT_W`, default `$clog2(TIMEOUT+1)`: width of the wait counter.

Ports:
- `clock` in 1: single system clock, rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `rd_req` in 1: read request, sampled in IDLE only.
- `wr_req` in 1: write request, sampled in IDLE only.
- `mem_ready` in 1: memory has completed the current access.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an access completes.
- `timeout_err` out 1: one-cycle pulse when an access is aborted on timeout.
- `MARin` out 1: MAR load enable.
- `MDRin` out 1: MDR load enable.
- `Read` out 1: MDR input select. 1 selects memory data; 0 selects BusMuxOut.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `wait_cnt` out CNT_W: current wait-cycle count, for debug and coverage.

## Operation

- All outputs are Moore outputs, decoded from the state register only. Any output not listed for a state is 0.
- State IDLE: `busy`=0.
  - If `rd_req` is high, go to RD_MAR.
  - Otherwise, if `wr_req` is high, go to WR_MAR.
  - If both are high, read wins and `wr_req` is dropped. It is not queued.
- State RD_MAR: `MARin`=1. Go to RD_WAIT and clear `wait_cnt` to 0.
- State RD_WAIT: `mem_rd`=1, `Read`=1.
  - If `mem_ready` is high, go to RD_CAP.
  - Otherwise, if `wait_cnt`==TIMEOUT-1, go to ERR.
  - Otherwise, increment `wait_cnt`.
- State RD_CAP: `mem_rd`=1, `Read`=1, `MDRin`=1. MDR captures the memory data. Go to DONE.
- State WR_MAR: `MARin`=1. Go to WR_LOAD.
- State WR_LOAD: `MDRin`=1, `Read`=0. MDR captures BusMuxOut. Go to WR_WAIT and clear `wait_cnt`.
- State WR_WAIT: `mem_wr`=1, `Read`=0. The exit rules and counter rules are the same as in RD_WAIT, except that the success exit goes to DONE.
- State DONE: `done`=1. Go to IDLE.
- State ERR: `timeout_err`=1. Go to IDLE. MDR is not loaded on a read timeout.
- `Read` is 0 in every state other than RD_WAIT and RD_CAP, so the MDR defaults to the bus path.
- While `busy`=1, `rd_req` and `wr_req` are ignored. A request still held high on return to IDLE starts a new access.
- `mem_ready` is ignored in every state except RD_WAIT and WR_WAIT.
- `wait_cnt` saturates by construction: it never exceeds TIMEOUT-1, and it holds its value outside the wait states.
- Illegal or unused state encodings go to IDLE on the next clock.

## Timing

- Reset:
  - Asserting `clear_n`=0 at any time forces state to IDLE and `wait_cnt` to 0 immediately, without waiting for a clock edge.
  - All outputs read 0 during reset.
  - An access in flight is abandoned with no `done` and no `timeout_err`.
- Read latency: a request sampled at edge 0 gives RD_MAR in cycle 1, RD_WAIT in cycles 2..2+N, RD_CAP in cycle 3+N and DONE in cycle 4+N. N is the number of wait cycles before `mem_ready` is seen, with N ≥ 0.
- Write latency: a request sampled at edge 0 gives WR_MAR in cycle 1, WR_LOAD in cycle 2, WR_WAIT in cycles 3..3+N and DONE in cycle 4+N.
- Timeout: the wait state is occupied for exactly TIMEOUT cycles and ERR occurs in the next cycle. If `mem_ready` arrives in the last wait cycle, success wins over timeout.
- Back-to-back accesses: DONE or ERR leads to IDLE, which can accept a new request. The minimum request-to-request spacing is 5 cycles.

## Test plan

- Reset check: hold `clear_n`=0 and toggle all inputs. All outputs must stay 0. Release reset and wait 3 cycles idle: `busy`=0.
- Read with zero wait: pulse `rd_req`, with `mem_ready` tied to 1.
  - `MARin` is high in cycle 1 and `mem_rd`/`Read` are high in cycles 2–3.
  - `MDRin` is high in cycle 3 only.
  - `done` is high in cycle 4 only.
- Write with 3 wait cycles: pulse `wr_req`, with `mem_ready` rising on the 4th WR_WAIT cycle.
  - `MDRin`=1 with `Read`=0 in cycle 2.
  - `mem_wr` is high in cycles 3–6 and `done` is high in cycle 7.
- Timeout with TIMEOUT=15: issue a read and hold `mem_ready`=0.
  - `mem_rd` is high for 15 cycles and `wait_cnt` reaches 14.
  - `timeout_err` pulses once, with `MDRin` never high.
  - Repeat with `mem_ready` high on the 15th wait cycle: the required result is `done` and no `timeout_err`.
- Arbitration and ignore: assert `rd_req` and `wr_req` together, so that a read must run. Pulse `wr_req` again mid-read: it must be ignored, and exactly one `done` pulse must occur.
- Reset mid-access: assert `clear_n`=0 during WR_WAIT. Outputs must go to 0 asynchronously. After release, state is IDLE and no `done` or `timeout_err` pulse occurs.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request, status and MAR/MDR/memory strobe bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
   parameter int CNT_W = 4
);
   logic             rd_req;
   logic             wr_req;
   logic             mem_ready;
   logic             busy;
   logic             done;
   logic             timeout_err;
   logic             MARin;
   logic             MDRin;
   logic             Read;
   logic             mem_rd;
   logic             mem_wr;
   logic [CNT_W-1:0] wait_cnt;

   // Control unit / memory side: raises requests and ready, observes strobes
   modport master (
      output rd_req, wr_req, mem_ready,
      input  busy, done, timeout_err, MARin, MDRin, Read, mem_rd, mem_wr, wait_cnt
   );

   // Sequencer side
   modport slave (
      input  rd_req, wr_req, mem_ready,
      output busy, done, timeout_err, MARin, MDRin, Read, mem_rd, mem_wr, wait_cnt
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-word MAR/MDR memory access sequencer with bounded ready wait
module mem_access_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input logic               clock,
   input logic               clear_n,
   mem_access_ctrl_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_RD_MAR  = 4'd1,
      S_RD_WAIT = 4'd2,
      S_RD_CAP  = 4'd3,
      S_WR_MAR  = 4'd4,
      S_WR_LOAD = 4'd5,
      S_WR_WAIT = 4'd6,
      S_DONE    = 4'd7,
      S_ERR     = 4'd8
   } state_t;

   // Last wait cycle index; reaching it without ready aborts the access
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic busy_q, done_q, err_q, marin_q, mdrin_q, read_q, mem_rd_q, mem_wr_q;

   // Next-state and wait-counter logic; counter only moves in the wait states
   always_comb begin
      nxt     = S_IDLE;
      cnt_nxt = cnt;
      case (state)
         S_IDLE: begin
            if (bus.rd_req)      nxt = S_RD_MAR;
            else if (bus.wr_req) nxt = S_WR_MAR;
            else                 nxt = S_IDLE;
         end
         S_RD_MAR: begin
            nxt     = S_RD_WAIT;
            cnt_nxt = '0;
         end
         S_RD_WAIT: begin
            if (bus.mem_ready)  nxt = S_RD_CAP;
            else if (cnt == LAST) nxt = S_ERR;
            else begin
               nxt     = S_RD_WAIT;
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_RD_CAP:  nxt = S_DONE;
         S_WR_MAR:  nxt = S_WR_LOAD;
         S_WR_LOAD: begin
            nxt     = S_WR_WAIT;
            cnt_nxt = '0;
         end
         S_WR_WAIT: begin
            if (bus.mem_ready)  nxt = S_DONE;
            else if (cnt == LAST) nxt = S_ERR;
            else begin
               nxt     = S_WR_WAIT;
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_DONE:  nxt = S_IDLE;
         S_ERR:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // State, counter and outputs registered together; outputs decode the state being entered
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         marin_q  <= 1'b0;
         mdrin_q  <= 1'b0;
         read_q   <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
      end else begin
         state    <= nxt;
         cnt      <= cnt_nxt;
         busy_q   <= (nxt != S_IDLE);
         done_q   <= (nxt == S_DONE);
         err_q    <= (nxt == S_ERR);
         marin_q  <= (nxt == S_RD_MAR) || (nxt == S_WR_MAR);
         mdrin_q  <= (nxt == S_RD_CAP) || (nxt == S_WR_LOAD);
         read_q   <= (nxt == S_RD_WAIT) || (nxt == S_RD_CAP);
         mem_rd_q <= (nxt == S_RD_WAIT) || (nxt == S_RD_CAP);
         mem_wr_q <= (nxt == S_WR_WAIT);
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = err_q;
   assign bus.MARin       = marin_q;
   assign bus.MDRin       = mdrin_q;
   assign bus.Read        = read_q;
   assign bus.mem_rd      = mem_rd_q;
   assign bus.mem_wr      = mem_wr_q;
   assign bus.wait_cnt    = cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - table-driven and sequence checks for mem_access_ctrl
module tb_mem_access_ctrl;

   logic clock;
   logic clear_n;
   int   checks;
   int   errors;

   mem_access_ctrl_if #(.CNT_W(4)) bus ();

   mem_access_ctrl #(.TIMEOUT(15)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {busy, done, timeout_err, MARin, MDRin, Read, mem_rd, mem_wr}
   function automatic logic [7:0] outs();
      return {bus.busy, bus.done, bus.timeout_err, bus.MARin,
              bus.MDRin, bus.Read, bus.mem_rd, bus.mem_wr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rd;
      logic       wr;
      logic       rdy;
      logic [7:0] eo;
      logic [3:0] ecnt;
   } vec_t;

   vec_t tbl[19];

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      int n_rd, n_mdr, n_err, n_done, max_cnt, wc;
      checks = 0;
      errors = 0;

      // row k: inputs before edge k, expected outputs in the cycle after edge k
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'b1001_0000, 4'd0}; // RD_MAR
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'b1000_0110, 4'd0}; // RD_WAIT
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'b1000_1110, 4'd0}; // RD_CAP
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'b1100_0000, 4'd0}; // DONE
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'b0000_0000, 4'd0}; // IDLE
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'b1001_0000, 4'd0}; // WR_MAR
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'b1000_1000, 4'd0}; // WR_LOAD
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0001, 4'd0}; // WR_WAIT 1
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0001, 4'd1}; // WR_WAIT 2
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0001, 4'd2}; // WR_WAIT 3
      tbl[10] = '{1'b0, 1'b0, 1'b0, 8'b1000_0001, 4'd3}; // WR_WAIT 4
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'b1100_0000, 4'd3}; // DONE
      tbl[12] = '{1'b0, 1'b0, 1'b1, 8'b0000_0000, 4'd3}; // IDLE, ready ignored, count held
      tbl[13] = '{1'b1, 1'b1, 1'b0, 8'b1001_0000, 4'd3}; // both: read wins
      tbl[14] = '{1'b0, 1'b1, 1'b0, 8'b1000_0110, 4'd0}; // wr ignored while busy
      tbl[15] = '{1'b0, 1'b0, 1'b0, 8'b1000_0110, 4'd1};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 8'b1000_1110, 4'd1}; // RD_CAP
      tbl[17] = '{1'b0, 1'b0, 1'b0, 8'b1100_0000, 4'd1}; // DONE
      tbl[18] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000, 4'd1}; // IDLE

      // Reset held: inputs toggle, outputs stay low
      clear_n = 1'b0;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         bus.rd_req = i[0]; bus.wr_req = i[1]; bus.mem_ready = ~i[0];
         cyc();
         chk("reset_outs", {20'd0, bus.wait_cnt, outs()}, 32'd0);
      end
      bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.mem_ready = 1'b0;
      clear_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);

      // Zero-wait read, 3-wait write, arbitration
      n_done = 0;
      for (int k = 0; k < 19; k++) begin
         bus.rd_req = tbl[k].rd; bus.wr_req = tbl[k].wr; bus.mem_ready = tbl[k].rdy;
         cyc();
         if (k >= 13) n_done += bus.done;
         chk($sformatf("vec%0d_outs", k), {24'd0, outs()}, {24'd0, tbl[k].eo});
         chk($sformatf("vec%0d_cnt", k), {28'd0, bus.wait_cnt}, {28'd0, tbl[k].ecnt});
      end
      chk("arb_done_count", n_done, 1);

      // Read timeout with ready held low
      n_rd = 0; n_mdr = 0; n_err = 0; n_done = 0; max_cnt = 0;
      bus.rd_req = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 0; i < 22; i++) begin
         cyc();
         bus.rd_req = 1'b0;
         n_rd  += bus.mem_rd;
         n_mdr += bus.MDRin;
         n_err += bus.timeout_err;
         n_done += bus.done;
         if (bus.mem_rd && int'(bus.wait_cnt) > max_cnt) max_cnt = int'(bus.wait_cnt);
      end
      chk("to_mem_rd_cycles", n_rd, 15);
      chk("to_max_cnt", max_cnt, 14);
      chk("to_err_pulses", n_err, 1);
      chk("to_mdrin", n_mdr, 0);
      chk("to_done", n_done, 0);
      chk("to_idle", {31'd0, bus.busy}, 32'd0);

      // Ready arrives in the 15th wait cycle: success wins
      n_mdr = 0; n_err = 0; n_done = 0; wc = 0;
      bus.rd_req = 1'b1;
      for (int i = 0; i < 22; i++) begin
         cyc();
         bus.rd_req = 1'b0;
         if (bus.Read && !bus.MDRin) wc++;
         bus.mem_ready = (bus.Read && !bus.MDRin && wc == 15);
         n_mdr  += bus.MDRin;
         n_err  += bus.timeout_err;
         n_done += bus.done;
      end
      bus.mem_ready = 1'b0;
      chk("late_wait_cycles", wc, 15);
      chk("late_done", n_done, 1);
      chk("late_err", n_err, 0);
      chk("late_mdrin", n_mdr, 1);

      // Reset during WR_WAIT
      bus.wr_req = 1'b1;
      cyc();
      bus.wr_req = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      chk("rst_pre_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
      #2 clear_n = 1'b0;
      #1;
      chk("rst_async_outs", {20'd0, bus.wait_cnt, outs()}, 32'd0);
      cyc();
      clear_n = 1'b1;
      n_done = 0; n_err = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_done += bus.done;
         n_err  += bus.timeout_err;
         chk("rst_post_busy", {31'd0, bus.busy}, 32'd0);
      end
      chk("rst_post_pulses", n_done + n_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
